// File: rtl/divisor_datapath.sv
// Datapath for a 16-bit restoring shift-subtract divider, steered by a one-hot
// controller state vector and reporting loop/zero status back to the controller.
module divisor_datapath #(
    parameter int unsigned N  = 16,
    parameter int unsigned CW = 5
) (
    input  logic         reloj,
    input  logic         reset,
    input  logic [7:0]   Est,
    input  logic [N-1:0] dividendo,
    input  logic [N-1:0] divisor,
    output logic         Cont16NoCero,
    output logic         divisorNoCero,
    output logic [N-1:0] cociente,
    output logic [N-1:0] residuo,
    output logic         error_div0
);

    localparam logic [7:0] S1 = 8'b0000_0010;
    localparam logic [7:0] S2 = 8'b0000_0100;
    localparam logic [7:0] S3 = 8'b0000_1000;
    localparam logic [7:0] S4 = 8'b0001_0000;
    localparam logic [7:0] S6 = 8'b0100_0000;

    logic [N-1:0]  quo_q, quo_d;
    logic [N-1:0]  dvs_q, dvs_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  coc_q, coc_d;
    logic [N-1:0]  res_q, res_d;
    logic          err_q, err_d;
    logic [N:0]    diff;

    // Extra MSB of the trial difference acts as the borrow.
    assign diff = {1'b0, rem_q} - {1'b0, dvs_q};

    always_comb begin
        quo_d = quo_q;
        dvs_d = dvs_q;
        rem_d = rem_q;
        cnt_d = cnt_q;
        coc_d = coc_q;
        res_d = res_q;
        err_d = err_q;
        // S0, S5, S7 and any non-one-hot vector hold everything.
        unique case (Est)
            S1: begin
                quo_d = dividendo;
                dvs_d = divisor;
                if (divisor == '0) begin
                    err_d = 1'b1;
                    coc_d = '1;
                    res_d = dividendo;
                end else begin
                    err_d = 1'b0;
                end
            end
            S2: begin
                rem_d = '0;
                cnt_d = CW'(N);
            end
            S3: begin
                {rem_d, quo_d} = {rem_q, quo_q} << 1;
            end
            S4: begin
                if (!diff[N]) begin
                    rem_d    = diff[N-1:0];
                    quo_d[0] = 1'b1;
                end
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S6: begin
                coc_d = quo_q;
                res_d = rem_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            quo_q <= '0;
            dvs_q <= '0;
            rem_q <= '0;
            cnt_q <= '0;
            coc_q <= '0;
            res_q <= '0;
            err_q <= 1'b0;
        end else begin
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            rem_q <= rem_d;
            cnt_q <= cnt_d;
            coc_q <= coc_d;
            res_q <= res_d;
            err_q <= err_d;
        end
    end

    assign Cont16NoCero  = (cnt_q != '0);
    assign divisorNoCero = (dvs_q != '0);
    assign cociente      = coc_q;
    assign residuo       = res_q;
    assign error_div0    = err_q;

endmodule

// File: tb/tb_divisor_datapath.sv
// Self-checking bench for divisor_datapath: directed corners plus random operands
// compared against plain integer division, and a behavioural controller for latency.
module tb_divisor_datapath;

    localparam int N = 16;

    logic          reloj = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    Est = 8'h00;
    logic [N-1:0]  dividendo = '0;
    logic [N-1:0]  divisor = '0;
    logic          Cont16NoCero;
    logic          divisorNoCero;
    logic [N-1:0]  cociente;
    logic [N-1:0]  residuo;
    logic          error_div0;

    int checks = 0;
    int errors = 0;

    localparam logic [7:0] E0 = 8'b0000_0001;
    localparam logic [7:0] E1 = 8'b0000_0010;
    localparam logic [7:0] E2 = 8'b0000_0100;
    localparam logic [7:0] E3 = 8'b0000_1000;
    localparam logic [7:0] E4 = 8'b0001_0000;
    localparam logic [7:0] E5 = 8'b0010_0000;
    localparam logic [7:0] E6 = 8'b0100_0000;
    localparam logic [7:0] E7 = 8'b1000_0000;

    divisor_datapath #(.N(N), .CW(5)) dut (
        .reloj        (reloj),
        .reset        (reset),
        .Est          (Est),
        .dividendo    (dividendo),
        .divisor      (divisor),
        .Cont16NoCero (Cont16NoCero),
        .divisorNoCero(divisorNoCero),
        .cociente     (cociente),
        .residuo      (residuo),
        .error_div0   (error_div0)
    );

    always #5 reloj = ~reloj;

    // Controller-style drive: state changes on negedge, sample 1 time unit after posedge.
    task automatic step(input logic [7:0] e);
        @(negedge reloj);
        Est = e;
        @(posedge reloj);
        #1;
    endtask

    task automatic run_div(input logic [N-1:0] a, input logic [N-1:0] b);
        dividendo = a;
        divisor   = b;
        step(E1);
        if (b != '0) begin
            step(E2);
            for (int k = 0; k < N; k++) begin
                step(E3);
                step(E4);
                step(E5);
            end
            step(E6);
        end
        step(E7);
    endtask

    function automatic logic [N-1:0] ref_q(input logic [N-1:0] a, input logic [N-1:0] b);
        return (b == '0) ? '1 : a / b;
    endfunction

    function automatic logic [N-1:0] ref_r(input logic [N-1:0] a, input logic [N-1:0] b);
        return (b == '0) ? a : a % b;
    endfunction

    task automatic test_reset;
        logic [N-1:0] ra, rb;
        repeat (2) @(posedge reloj);
        #1;
        checks++;
        if ({cociente, residuo, error_div0, Cont16NoCero, divisorNoCero} !== '0) begin
            errors++;
            $display("FAIL reset_state: got coc=%0d res=%0d err=%0b cnt=%0b dnz=%0b want all 0",
                     cociente, residuo, error_div0, Cont16NoCero, divisorNoCero);
        end
        @(negedge reloj);
        reset = 1'b1;
        run_div(16'd100, 16'd7);
        checks++;
        if (cociente !== 16'd14 || residuo !== 16'd2) begin
            errors++;
            $display("FAIL pre_reset_div: got %0d r %0d want 14 r 2", cociente, residuo);
        end
        // Abort a new division during its 5th shift.
        ra = 16'd50000; rb = 16'd3;
        dividendo = ra; divisor = rb;
        step(E1);
        step(E2);
        for (int k = 0; k < 4; k++) begin
            step(E3); step(E4); step(E5);
        end
        step(E3);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({cociente, residuo, error_div0, Cont16NoCero, divisorNoCero} !== '0) begin
            errors++;
            $display("FAIL async_reset: got coc=%0d res=%0d err=%0b cnt=%0b dnz=%0b want all 0",
                     cociente, residuo, error_div0, Cont16NoCero, divisorNoCero);
        end
        @(negedge reloj);
        Est = E0;
        reset = 1'b1;
        repeat (2) step(E0);
        checks++;
        if ({cociente, residuo, error_div0, Cont16NoCero, divisorNoCero} !== '0) begin
            errors++;
            $display("FAIL post_reset_idle: got coc=%0d res=%0d err=%0b want all 0",
                     cociente, residuo, error_div0);
        end
    endtask

    task automatic test_basic;
        dividendo = 16'd100;
        divisor   = 16'd7;
        step(E1);
        step(E2);
        for (int k = 1; k <= N; k++) begin
            step(E3);
            step(E4);
            step(E5);
            checks++;
            if (Cont16NoCero !== (k < N)) begin
                errors++;
                $display("FAIL cont_s5_%0d: got %0b want %0b", k, Cont16NoCero, (k < N));
            end
        end
        step(E6);
        checks++;
        if (cociente !== 16'd14 || residuo !== 16'd2 || error_div0 !== 1'b0) begin
            errors++;
            $display("FAIL div_100_7: got %0d r %0d err %0b want 14 r 2 err 0",
                     cociente, residuo, error_div0);
        end
    endtask

    task automatic test_corners;
        logic [N-1:0] ta [3];
        logic [N-1:0] tb [3];
        ta[0] = 16'hFFFF; tb[0] = 16'd1;
        ta[1] = 16'd5;    tb[1] = 16'd9;
        ta[2] = 16'hFFFF; tb[2] = 16'hFFFF;
        for (int i = 0; i < 3; i++) begin
            run_div(ta[i], tb[i]);
            checks++;
            if (cociente !== ref_q(ta[i], tb[i]) || residuo !== ref_r(ta[i], tb[i])) begin
                errors++;
                $display("FAIL corner_%0d (%0d/%0d): got %0d r %0d want %0d r %0d", i, ta[i],
                         tb[i], cociente, residuo, ref_q(ta[i], tb[i]), ref_r(ta[i], tb[i]));
            end
        end
    endtask

    task automatic test_div0;
        dividendo = 16'd1234;
        divisor   = 16'd0;
        step(E1);
        checks++;
        if (divisorNoCero !== 1'b0 || error_div0 !== 1'b1 || cociente !== 16'hFFFF ||
            residuo !== 16'd1234) begin
            errors++;
            $display("FAIL div0: got dnz=%0b err=%0b coc=%h res=%0d want 0 1 ffff 1234",
                     divisorNoCero, error_div0, cociente, residuo);
        end
        step(E7);
        run_div(16'd60, 16'd6);
        checks++;
        if (error_div0 !== 1'b0 || cociente !== 16'd10 || residuo !== 16'd0) begin
            errors++;
            $display("FAIL div0_clear: got err=%0b coc=%0d res=%0d want 0 10 0",
                     error_div0, cociente, residuo);
        end
    endtask

    task automatic test_illegal;
        logic [N-1:0] hc, hr;
        logic         hcnt;
        dividendo = 16'd40000;
        divisor   = 16'd123;
        step(E1);
        step(E2);
        for (int k = 0; k < 8; k++) begin
            step(E3); step(E4); step(E5);
        end
        hc = cociente; hr = residuo; hcnt = Cont16NoCero;
        for (int k = 0; k < 3; k++) step(8'h00);
        for (int k = 0; k < 3; k++) step(8'b0001_1000);
        checks++;
        if (cociente !== hc || residuo !== hr || Cont16NoCero !== hcnt ||
            divisorNoCero !== 1'b1 || error_div0 !== 1'b0) begin
            errors++;
            $display("FAIL illegal_hold: got coc=%0d res=%0d cnt=%0b want %0d %0d %0b",
                     cociente, residuo, Cont16NoCero, hc, hr, hcnt);
        end
        for (int k = 0; k < 8; k++) begin
            step(E3); step(E4); step(E5);
        end
        step(E6);
        checks++;
        if (cociente !== 16'd325 || residuo !== 16'd25) begin
            errors++;
            $display("FAIL illegal_resume: got %0d r %0d want 325 r 25", cociente, residuo);
        end
    endtask

    task automatic test_random;
        logic [N-1:0] a, b;
        for (int i = 0; i < 24; i++) begin
            a = N'($urandom_range(0, 65535));
            case (i % 3)
                0: b = N'($urandom_range(1, 15));
                1: b = N'($urandom_range(1, 65535));
                default: b = N'($urandom_range(0, 300));
            endcase
            run_div(a, b);
            checks++;
            if (cociente !== ref_q(a, b) || residuo !== ref_r(a, b) ||
                error_div0 !== (b == '0)) begin
                errors++;
                $display("FAIL random_%0d (%0d/%0d): got %0d r %0d e %0b want %0d r %0d e %0b",
                         i, a, b, cociente, residuo, error_div0, ref_q(a, b), ref_r(a, b),
                         (b == '0));
            end
        end
    endtask

    task automatic test_back_to_back;
        run_div(16'd999, 16'd10);
        dividendo = 16'd7;
        divisor   = 16'd2;
        step(E1);
        checks++;
        if (cociente !== 16'd99 || residuo !== 16'd9) begin
            errors++;
            $display("FAIL b2b_hold: got %0d r %0d want 99 r 9", cociente, residuo);
        end
        step(E2);
        for (int k = 0; k < N; k++) begin
            step(E3); step(E4); step(E5);
        end
        checks++;
        if (cociente !== 16'd99 || residuo !== 16'd9) begin
            errors++;
            $display("FAIL b2b_pre_publish: got %0d r %0d want 99 r 9", cociente, residuo);
        end
        step(E6);
        checks++;
        if (cociente !== 16'd3 || residuo !== 16'd1) begin
            errors++;
            $display("FAIL b2b_result: got %0d r %0d want 3 r 1", cociente, residuo);
        end
    endtask

    // Behavioural controller: go -> S1, zero divisor -> S7, loop while counter nonzero.
    task automatic test_system(input logic [N-1:0] a, input logic [N-1:0] b, input bit chk_lat);
        int st;
        int lat;
        int guard;
        st = 0; lat = 0; guard = 0;
        dividendo = a;
        divisor   = b;
        @(negedge reloj);
        st = 1;
        Est = E1;
        while (st != 7 && guard < 300) begin
            @(posedge reloj);
            #1;
            lat++;
            guard++;
            @(negedge reloj);
            case (st)
                1: st = divisorNoCero ? 2 : 7;
                5: st = Cont16NoCero ? 3 : 6;
                default: st = st + 1;
            endcase
            Est = 8'(1 << st);
        end
        checks++;
        if (st != 7) begin
            errors++;
            $display("FAIL sys_timeout: controller did not reach S7 within %0d clocks", guard);
        end
        if (chk_lat) begin
            checks++;
            if (lat != 3 * N + 3) begin
                errors++;
                $display("FAIL sys_latency: got %0d clocks want %0d", lat, 3 * N + 3);
            end
        end
        repeat (2) @(posedge reloj);
        @(negedge reloj);
        Est = E0;
        repeat (3) @(posedge reloj);
        #1;
        checks++;
        if (cociente !== ref_q(a, b) || residuo !== ref_r(a, b)) begin
            errors++;
            $display("FAIL sys_result (%0d/%0d): got %0d r %0d want %0d r %0d", a, b,
                     cociente, residuo, ref_q(a, b), ref_r(a, b));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corners();
        test_div0();
        test_illegal();
        test_random();
        test_back_to_back();
        test_system(16'd1000, 16'd33, 1'b1);
        for (int i = 0; i < 4; i++) begin
            test_system(N'($urandom_range(0, 65535)), N'($urandom_range(1, 2000)), 1'b1);
        end
        test_system(16'd77, 16'd0, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/divisor_datapath.md
Name: divisor_datapath

Overview:
- Datapath for the 16-bit restoring shift-subtract divider. It is driven by the one-hot state vector Est[7:0] from the Richards-style divider controller.
- It returns the two status conditions the controller branches on: Cont16NoCero and divisorNoCero.
- It holds the dividend, divisor, partial-remainder and iteration-counter registers, and publishes quotient, remainder and a divide-by-zero flag.

Parameters:
- N, 16, operand/quotient/remainder width in bits.
- CW, 5, iteration-counter width; must satisfy 2^CW > N.

Ports:
- reloj  input  1  system clock; datapath registers update on posedge (controller advances on negedge, giving half-cycle settling).
- reset  input  1  asynchronous, active-low reset.
- Est  input  8  one-hot controller state; Est[k]=1 means state Sk.
- dividendo  input  N  dividend operand, sampled in S1.
- divisor  input  N  divisor operand, sampled in S1.
- Cont16NoCero  output  1  combinational: iteration counter != 0.
- divisorNoCero  output  1  combinational: divisor register != 0.
- cociente  output  N  registered quotient result.
- residuo  output  N  registered remainder result.
- error_div0  output  1  registered flag: last operation had a zero divisor.

Behaviour:
- Reset (reset=0, asynchronous): all registers cleared immediately.
  - Registers: Q_reg, D_reg, R_reg, count, cociente, residuo, error_div0 all = 0.
  - Hence Cont16NoCero=0 and divisorNoCero=0.
  - Reset asserted mid-division aborts it; no partial result reaches cociente/residuo.
- State actions, all at posedge reloj, only when Est is exactly one-hot:
  - S0 (idle, wait go): hold all registers.
  - S1 (load / check): Q_reg<=dividendo, D_reg<=divisor.
    - If divisor==0: error_div0<=1, cociente<=all ones, residuo<=dividendo. The controller then jumps to S7.
    - Else: error_div0<=0.
  - S2 (init): R_reg<=0, count<=N.
  - S3 (shift): {R_reg,Q_reg} <= {R_reg,Q_reg} << 1, with LSB filled 0.
  - S4 (trial subtract): compute diff = R_reg - D_reg at N+1 bits.
    - If no borrow (R_reg>=D_reg): R_reg<=diff[N-1:0], Q_reg[0]<=1.
    - Else: R_reg unchanged.
    - In both cases count<=count-1.
  - S5 (loop test): hold. The controller samples Cont16NoCero at the following negedge; nonzero returns to S3.
  - S6 (publish): cociente<=Q_reg, residuo<=R_reg.
  - S7 (done, wait go low): hold; results stable.
- Est not one-hot (all zero or multiple bits set): hold every register; no error output.
- cociente, residuo and error_div0 change only in S1 (zero-divisor case or flag clear) or S6. They are stable at all other times.
- Counter behaviour:
  - Never decrements below 0. If S4 is entered with count==0, count stays 0.
  - Exactly N S3/S4/S5 passes per division.
- Latency from S1 to S7 with nonzero divisor: 1 (S1) + 1 (S2) + 3N (loops) + 1 (S6) = 3N+3 clocks; 51 for N=16.
- Arithmetic: unsigned. Remainder is always < divisor when the divisor is nonzero. Invariant: dividendo = cociente*divisor + residuo.
- Back-to-back operation: a new S1 overwrites Q_reg/D_reg. Previous results remain on cociente/residuo until the next S6 or zero-divisor S1.

Test Plan:
- Reset low mid-loop (e.g. during the 5th S3), with prior results cociente=14, residuo=2 → all outputs 0 immediately (asynchronous). Cont16NoCero=0, divisorNoCero=0.
- Drive Est S1 with dividendo=100, divisor=7, then S2, 16×(S3,S4,S5), S6 → cociente=14, residuo=2, error_div0=0. Cont16NoCero=1 on the first 15 S5 visits and 0 on the 16th.
- dividendo=65535, divisor=1 → cociente=65535, residuo=0. dividendo=5, divisor=9 → cociente=0, residuo=5.
- S1 with divisor=0, dividendo=1234 → divisorNoCero=0 after that posedge, error_div0=1, cociente=16'hFFFF, residuo=1234. A following valid division (60/6 → cociente=10, residuo=0) clears error_div0.
- Est=8'b0000_0000 or 8'b0001_1000 held for several clocks mid-division → no register changes. Resuming the valid sequence yields the correct result.
- Full system with Ctrl_Richards:
  - Raise go with 1000/33 and count clocks until Est[7] → 51 clocks after S1 entry; cociente=30, residuo=10.
  - Drop go → controller returns to S0 with results held.
